frame_sync_ctrl: RTL and testbench



---
 rtl/frame_sync_pkg.sv | 15 +
 rtl/frame_sync_ctrl_sync_pat_match.sv | 36 +++
 rtl/frame_sync_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_frame_sync_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sync_pkg.sv
// Shared definitions for the frame synchroniser: state encoding and counter sizing.
package frame_sync_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] HUNT   = 2'd0;
   localparam logic [STATE_W-1:0] VERIFY = 2'd1;
   localparam logic [STATE_W-1:0] LOCKED = 2'd2;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/frame_sync_ctrl_sync_pat_match.sv
// Sync-pattern detector: bit history, fill tracking and a Mealy match that includes the current bit.
module sync_pat_match #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic x,
   output logic match
);

   localparam int FILL_W = $clog2(PAT_W + 1);

   logic [PAT_W-2:0]  sr_r;
   logic [FILL_W-1:0] fill_r;
   logic [PAT_W-1:0]  window_s;

   assign window_s = {sr_r, x};

   // Shift in accepted bits and count how many are valid, saturating at PAT_W.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_r   <= '0;
         fill_r <= '0;
      end else if (en) begin
         sr_r <= window_s[PAT_W-2:0];
         if (fill_r != FILL_W'(PAT_W)) begin
            fill_r <= fill_r + FILL_W'(1);
         end
      end
   end

   assign match = en && (fill_r >= FILL_W'(PAT_W - 1)) && (window_s == PATTERN);

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame-sync controller: hunt, verify and flywheel lock on a periodic sync pattern.
// Optional statistics counters (frame_cnt, slip_cnt) are built when FRAME_SYNC_STATS_EN is defined.
module frame_sync_ctrl
   import frame_sync_pkg::*;
#(
   parameter int               PAT_W     = 4,
   parameter logic [PAT_W-1:0] PATTERN   = 4'b1011,
   parameter int               FRAME_LEN = 16,
   parameter int               LOCK_CNT  = 3,
   parameter int               LOSS_CNT  = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               en,
   input  logic                               x,
   output logic                               locked,
   output logic                               frame_start,
   output logic                               sync_err,
   output logic [cnt_width(FRAME_LEN)-1:0]    bit_cnt,
   output logic [STATE_W-1:0]                 state_o
`ifdef FRAME_SYNC_STATS_EN
   ,
   output logic [15:0]                        frame_cnt,
   output logic [7:0]                         slip_cnt
`endif
);

   localparam int CNT_W  = cnt_width(FRAME_LEN);
   localparam int HIT_W  = cnt_width(LOCK_CNT + 1);
   localparam int MISS_W = cnt_width(LOSS_CNT + 1);

   logic [STATE_W-1:0] state_r, state_nx_s;
   logic [CNT_W-1:0]   bit_cnt_r, bit_nx_s, bit_step_s;
   logic [HIT_W-1:0]   hit_cnt_r, hit_nx_s, hit_inc_s;
   logic [MISS_W-1:0]  miss_cnt_r, miss_nx_s, miss_inc_s;
   logic               match_s, chk_s;
   logic               locked_s, frame_start_s, sync_err_s;
   logic               locked_r, frame_start_r, sync_err_r;

   sync_pat_match #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_match (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .x     (x),
      .match (match_s)
   );

   assign chk_s      = en && (bit_cnt_r == CNT_W'(FRAME_LEN - 1));
   assign bit_step_s = chk_s ? '0 : bit_cnt_r + CNT_W'(1);
   assign hit_inc_s  = hit_cnt_r + HIT_W'(1);
   assign miss_inc_s = miss_cnt_r + MISS_W'(1);

   // State, counters and registered output pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= HUNT;
         bit_cnt_r     <= '0;
         hit_cnt_r     <= '0;
         miss_cnt_r    <= '0;
         locked_r      <= 1'b0;
         frame_start_r <= 1'b0;
         sync_err_r    <= 1'b0;
      end else begin
         state_r       <= state_nx_s;
         bit_cnt_r     <= bit_nx_s;
         hit_cnt_r     <= hit_nx_s;
         miss_cnt_r    <= miss_nx_s;
         locked_r      <= locked_s;
         frame_start_r <= frame_start_s;
         sync_err_r    <= sync_err_s;
      end
   end

   // Next state and counter updates; off-checkpoint matches are ignored outside HUNT.
   always_comb begin
      state_nx_s = state_r;
      bit_nx_s   = bit_cnt_r;
      hit_nx_s   = hit_cnt_r;
      miss_nx_s  = miss_cnt_r;
      case (state_r)
         HUNT: begin
            bit_nx_s = '0;
            if (match_s) begin
               hit_nx_s   = HIT_W'(1);
               miss_nx_s  = '0;
               state_nx_s = (LOCK_CNT == 1) ? LOCKED : VERIFY;
            end else begin
               hit_nx_s   = '0;
               state_nx_s = HUNT;
            end
         end
         VERIFY: begin
            if (en) begin
               bit_nx_s = bit_step_s;
            end else begin
               bit_nx_s = bit_cnt_r;
            end
            if (chk_s && match_s) begin
               hit_nx_s = hit_inc_s;
               if (hit_inc_s == HIT_W'(LOCK_CNT)) begin
                  state_nx_s = LOCKED;
                  miss_nx_s  = '0;
               end else begin
                  state_nx_s = VERIFY;
               end
            end else if (chk_s) begin
               state_nx_s = HUNT;
               hit_nx_s   = '0;
            end else begin
               state_nx_s = VERIFY;
            end
         end
         LOCKED: begin
            if (en) begin
               bit_nx_s = bit_step_s;
            end else begin
               bit_nx_s = bit_cnt_r;
            end
            if (chk_s && match_s) begin
               miss_nx_s = '0;
            end else if (chk_s) begin
               if (miss_inc_s == MISS_W'(LOSS_CNT)) begin
                  state_nx_s = HUNT;
                  miss_nx_s  = '0;
                  hit_nx_s   = '0;
               end else begin
                  miss_nx_s = miss_inc_s;
               end
            end else begin
               state_nx_s = LOCKED;
            end
         end
         default: begin
            state_nx_s = HUNT;
            bit_nx_s   = '0;
            hit_nx_s   = '0;
            miss_nx_s  = '0;
         end
      endcase
   end

   // Output decode; a losing checkpoint reports sync_err but not frame_start.
   always_comb begin
      locked_s = (state_nx_s == LOCKED);
      if ((state_r == LOCKED) && chk_s) begin
         sync_err_s    = !match_s;
         frame_start_s = (state_nx_s == LOCKED);
      end else begin
         sync_err_s    = 1'b0;
         frame_start_s = 1'b0;
      end
   end

   assign locked      = locked_r;
   assign frame_start = frame_start_r;
   assign sync_err    = sync_err_r;
   assign bit_cnt     = bit_cnt_r;
   assign state_o     = state_r;

`ifdef FRAME_SYNC_STATS_EN
   logic [15:0] frame_cnt_r;
   logic [7:0]  slip_cnt_r;

   // Frame count wraps; slip count saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_r <= 16'd0;
         slip_cnt_r  <= 8'd0;
      end else begin
         if (frame_start_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end
         if ((state_r == LOCKED) && (state_nx_s == HUNT) && (slip_cnt_r != 8'hFF)) begin
            slip_cnt_r <= slip_cnt_r + 8'd1;
         end
      end
   end

   assign frame_cnt = frame_cnt_r;
   assign slip_cnt  = slip_cnt_r;
`endif

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Self-checking bench for frame_sync_ctrl: bit-history reference model plus directed literal pins.
`timescale 1ns/1ps
module tb_frame_sync_ctrl;

   localparam int PW  = 4;
   localparam int PAT = 11;
   localparam int FL  = 16;
   localparam int LK  = 3;
   localparam int LS  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       x = 1'b0;
   logic       locked, frame_start, sync_err;
   logic [3:0] bit_cnt;
   logic [1:0] state_o;
`ifdef FRAME_SYNC_STATS_EN
   logic [15:0] frame_cnt;
   logic [7:0]  slip_cnt;
`endif

   always #5 clk = ~clk;

   frame_sync_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .x           (x),
      .locked      (locked),
      .frame_start (frame_start),
      .sync_err    (sync_err),
      .bit_cnt     (bit_cnt),
      .state_o     (state_o)
`ifdef FRAME_SYNC_STATS_EN
      ,
      .frame_cnt   (frame_cnt),
      .slip_cnt    (slip_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Reference model: mode 0=hunt, 1=verify, 2=locked; hist holds the last accepted bits.
   int m_mode, m_pos, m_hits, m_miss, m_frames, m_slips;
   int e_fs, e_err;
   bit hist[$];

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit b);
      int v;
      bit hit, chk;
      e_fs  = 0;
      e_err = 0;
      if (r) begin
         m_mode = 0; m_pos = 0; m_hits = 0; m_miss = 0; m_frames = 0; m_slips = 0;
         hist.delete();
         return;
      end
      if (!e) return;
      hist.push_back(b);
      if (hist.size() > PW) void'(hist.pop_front());
      v = 0;
      foreach (hist[i]) v = v * 2 + int'(hist[i]);
      hit   = (hist.size() == PW) && (v == PAT);
      chk   = (m_pos == FL - 1);
      m_pos = (m_mode == 0 || chk) ? 0 : m_pos + 1;
      if (m_mode == 0) begin
         if (hit) begin
            m_hits = 1;
            m_miss = 0;
            m_mode = (LK == 1) ? 2 : 1;
         end
      end else if (m_mode == 1) begin
         if (chk && hit) begin
            m_hits++;
            if (m_hits == LK) begin
               m_mode = 2;
               m_miss = 0;
            end
         end else if (chk) begin
            m_mode = 0;
            m_hits = 0;
         end
      end else begin
         if (chk && hit) begin
            m_miss = 0;
            e_fs   = 1;
         end else if (chk) begin
            e_err = 1;
            m_miss++;
            if (m_miss == LS) begin
               m_mode = 0; m_miss = 0; m_hits = 0;
               if (m_slips < 255) m_slips++;
            end else begin
               e_fs = 1;
            end
         end
      end
      if (e_fs != 0) m_frames++;
   endtask

   // One clock: drive on the falling edge, step the model, compare just after the rising edge.
   task automatic tick(input bit r, input bit e, input bit b);
      @(negedge clk);
      reset = r;
      en    = e;
      x     = b;
      model_step(r, e, b);
      @(posedge clk);
      #1;
      check("locked", int'(locked), (m_mode == 2) ? 1 : 0);
      check("frame_start", int'(frame_start), e_fs);
      check("sync_err", int'(sync_err), e_err);
      check("bit_cnt", int'(bit_cnt), m_pos);
      check("state_o", int'(state_o), m_mode);
`ifdef FRAME_SYNC_STATS_EN
      check("frame_cnt", int'(frame_cnt), m_frames % 65536);
      check("slip_cnt", int'(slip_cnt), m_slips);
`endif
   endtask

   task automatic send_bit(input bit b, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
      tick(1'b0, 1'b1, b);
   endtask

   // 12 payload bits then the 4 sync bits MSB first; hold_last leaves the final sync bit to the caller.
   task automatic send_frame(input logic [3:0] s, input bit gaps, input bit hold_last, input bit rnd);
      for (int i = 0; i < 12; i++) send_bit(rnd ? 1'($urandom_range(0, 1)) : 1'b0, gaps);
      for (int i = 3; i >= (hold_last ? 1 : 0); i--) send_bit(s[i], gaps);
   endtask

   initial begin
      logic [3:0] s;

      // Reset state
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      check("reset_locked", int'(locked), 0);
      check("reset_state", int'(state_o), 0);
      check("reset_bitcnt", int'(bit_cnt), 0);

      // Lock after three frames: locked one cycle after bit 47
      send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
      send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
      send_frame(4'b1011, 1'b0, 1'b1, 1'b0);
      check("pre_lock_locked", int'(locked), 0);
      check("pre_lock_state", int'(state_o), 1);
      send_bit(1'b1, 1'b0);
      check("lock_locked", int'(locked), 1);
      check("lock_state", int'(state_o), 2);
      check("lock_bitcnt", int'(bit_cnt), 0);
      check("lock_no_fs", int'(frame_start), 0);
      send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
      check("locked_fs", int'(frame_start), 1);
      check("locked_bitcnt", int'(bit_cnt), 0);

      // Single corrupt sync flywheels; two in a row drop lock
      send_frame(4'b1001, 1'b0, 1'b0, 1'b0);
      check("fly_err", int'(sync_err), 1);
      check("fly_fs", int'(frame_start), 1);
      check("fly_locked", int'(locked), 1);
      send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
      send_frame(4'b1001, 1'b0, 1'b0, 1'b0);
      send_frame(4'b1001, 1'b0, 1'b0, 1'b0);
      check("loss_locked", int'(locked), 0);
      check("loss_state", int'(state_o), 0);
      check("loss_err", int'(sync_err), 1);
      check("loss_no_fs", int'(frame_start), 0);

      // Verify failure returns to hunt
      tick(1'b1, 1'b0, 1'b0);
      send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
      check("verify_state", int'(state_o), 1);
      send_frame(4'b0000, 1'b0, 1'b0, 1'b0);
      check("vfail_state", int'(state_o), 0);
      check("vfail_locked", int'(locked), 0);

      // Same lock sequence with random en gaps
      tick(1'b1, 1'b0, 1'b0);
      send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
      send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
      send_frame(4'b1011, 1'b1, 1'b1, 1'b0);
      check("gap_pre_locked", int'(locked), 0);
      send_bit(1'b1, 1'b1);
      check("gap_locked", int'(locked), 1);
      send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
      check("gap_fs", int'(frame_start), 1);

      // Reset while locked mid-frame, then relock needs three fresh frames
      for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
      check("mid_bitcnt", int'(bit_cnt), 7);
      tick(1'b1, 1'b1, 1'b0);
      check("rst_locked", int'(locked), 0);
      check("rst_bitcnt", int'(bit_cnt), 0);
      send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
      send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
      check("relock_early", int'(locked), 0);
      send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
      check("relock", int'(locked), 1);

`ifdef FRAME_SYNC_STATS_EN
      // Ten locked frames then forced loss
      tick(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 13; i++) send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
      check("stats_frames10", int'(frame_cnt), 10);
      send_frame(4'b0000, 1'b0, 1'b0, 1'b0);
      send_frame(4'b0000, 1'b0, 1'b0, 1'b0);
      check("stats_frames11", int'(frame_cnt), 11);
      check("stats_slip", int'(slip_cnt), 1);
`endif

      // Randomized frames, payload, en gaps and occasional resets
      for (int f = 0; f < 80; f++) begin
         if ($urandom_range(0, 29) == 0) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
         s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b1011;
         send_frame(s, 1'b1, 1'b0, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
